// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// one-hot column drives, key codes and small column helpers.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] COL0 = 4'b0001;
    localparam logic [3:0] COL1 = 4'b0010;
    localparam logic [3:0] COL2 = 4'b0100;
    localparam logic [3:0] COL3 = 4'b1000;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Zero and multi-key (ghost) samples are both rejected by this test.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Panel-side bundle of the keypad scanner: row inputs, column drive and
// the decoded key outputs. slave = scanner, master = panel/downstream.
interface keypad_scanner_if;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] num;
    logic       key_valid;
    logic       key_pressed;

    modport slave  (input fil, output col, num, key_valid, key_pressed);
    modport master (output fil, input col, num, key_valid, key_pressed);
endinterface

// File: rtl/keypad_decode.sv
// Combinational key map: one-hot column and one-hot row to the 4-bit key code.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] col,
    input  logic [3:0] fil,
    output logic [3:0] num
);

    always_comb begin
        num = KEY_0;
        case (col)
            COL0: case (fil)
                4'b0001: num = KEY_1;
                4'b0010: num = KEY_4;
                4'b0100: num = KEY_7;
                4'b1000: num = KEY_F;
                default: num = KEY_0;
            endcase
            COL1: case (fil)
                4'b0001: num = KEY_2;
                4'b0010: num = KEY_5;
                4'b0100: num = KEY_8;
                4'b1000: num = KEY_0;
                default: num = KEY_0;
            endcase
            COL2: case (fil)
                4'b0001: num = KEY_3;
                4'b0010: num = KEY_6;
                4'b0100: num = KEY_9;
                4'b1000: num = KEY_E;
                default: num = KEY_0;
            endcase
            COL3: case (fil)
                4'b0001: num = KEY_A;
                4'b0010: num = KEY_B;
                4'b0100: num = KEY_C;
                4'b1000: num = KEY_D;
                default: num = KEY_0;
            endcase
            default: num = KEY_0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, dwell timer, debounce/hold FSM.
// Define KEYPAD_REPEAT_EN to re-strobe a held key every REPEAT_SAMPLES samples.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_CNT   = 3,
    parameter int REPEAT_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.slave  kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_CNT);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_SAMPLES < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    logic [3:0]       sync1, sync2;
    logic [DIV_W-1:0] dwell;
    logic             sample_en;
    state_t           state, state_n;
    logic [3:0]       col_q, col_n, num_q, num_n;
    logic             valid_q, valid_n, pressed_q, pressed_n;
    logic [3:0]       key_fil, key_fil_n, key_col, key_col_n;
    logic [CNT_W-1:0] deb_cnt, deb_n, rel_cnt, rel_n;
    logic             accept;
    logic [3:0]       dec_col, dec_fil, dec_num;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_SAMPLES);
    logic [REP_W-1:0] rep_cnt, rep_n;
`endif

    assign sample_en = (dwell == DWELL_LAST);

    // In SCAN the key being accepted has not been latched yet, so decode the live sample.
    assign dec_col = (state == SCAN) ? col_q : key_col;
    assign dec_fil = (state == SCAN) ? sync2 : key_fil;

    keypad_decode u_decode (.col(dec_col), .fil(dec_fil), .num(dec_num));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            dwell <= '0;
        end else begin
            sync1 <= kp.fil;
            sync2 <= sync1;
            dwell <= sample_en ? '0 : dwell + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_q     <= COL0;
            num_q     <= KEY_0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            key_fil   <= '0;
            key_col   <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            col_q     <= col_n;
            num_q     <= num_n;
            valid_q   <= valid_n;
            pressed_q <= pressed_n;
            key_fil   <= key_fil_n;
            key_col   <= key_col_n;
            deb_cnt   <= deb_n;
            rel_cnt   <= rel_n;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col_q;
        num_n     = num_q;
        valid_n   = 1'b0;
        pressed_n = pressed_q;
        key_fil_n = key_fil;
        key_col_n = key_col;
        deb_n     = deb_cnt;
        rel_n     = rel_cnt;
        accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n     = rep_cnt;
`endif
        if (sample_en) begin
            unique case (state)
                SCAN: begin
                    if (is_onehot(sync2)) begin
                        key_fil_n = sync2;
                        key_col_n = col_q;
                        deb_n     = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) accept = 1'b1;
                        else                   state_n = DEBOUNCE;
                    end else begin
                        col_n = next_col(col_q);
                    end
                end
                DEBOUNCE: begin
                    if (sync2 == key_fil) begin
                        if (deb_cnt + CNT_W'(1) == CNT_DONE) accept = 1'b1;
                        else                                 deb_n  = deb_cnt + CNT_W'(1);
                    end else begin
                        state_n = SCAN;
                        col_n   = next_col(col_q);
                    end
                end
                HELD: begin
                    if ((sync2 & key_fil) == 4'b0000) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_n = '0;
`endif
                        if (rel_cnt + CNT_W'(1) == CNT_DONE) begin
                            pressed_n = 1'b0;
                            rel_n     = '0;
                            state_n   = SCAN;
                            col_n     = next_col(col_q);
                        end else begin
                            rel_n = rel_cnt + CNT_W'(1);
                        end
                    end else begin
                        rel_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt + REP_W'(1) == REP_DONE) begin
                            valid_n = 1'b1;
                            rep_n   = '0;
                        end else begin
                            rep_n = rep_cnt + REP_W'(1);
                        end
`endif
                    end
                end
                default: state_n = SCAN;
            endcase
            if (accept) begin
                num_n     = dec_num;
                valid_n   = 1'b1;
                pressed_n = 1'b1;
                rel_n     = '0;
                state_n   = HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_n     = '0;
`endif
            end
        end
    end

    assign kp.col         = col_q;
    assign kp.num         = num_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a behavioural keypad matrix drives fil,
// expected key codes are queued at stimulus time and popped on every strobe.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_SAMPLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .kp(kif)
    );

    // keys[c][r]: switch at column c / row r closed
    logic [3:0][3:0] keys = '0;
    assign kif.fil = ({4{kif.col[0]}} & keys[0]) | ({4{kif.col[1]}} & keys[1]) |
                     ({4{kif.col[2]}} & keys[2]) | ({4{kif.col[3]}} & keys[3]);

    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'hF},
                                '{4'h2, 4'h5, 4'h8, 4'h0},
                                '{4'h3, 4'h6, 4'h9, 4'hE},
                                '{4'hA, 4'hB, 4'hC, 4'hD}};

    logic [3:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (kif.key_valid) begin
                strobes++;
                check("valid_back_to_back", int'(prev_valid), 0);
                check("pressed_with_valid", int'(kif.key_pressed), 1);
                if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
                else                   check("strobe_num", int'(kif.num), int'(exp_q.pop_front()));
            end
            prev_valid = kif.key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (kif.key_valid) begin
                n = i;
                return;
            end
        end
        check("strobe_timeout", 0, 1);
    endtask

    task automatic wait_col(input logic [3:0] c, output int n);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (kif.col == c) begin
                n = i;
                return;
            end
        end
        check("col_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        logic [3:0] seen;
        int order [16];

        // Idle scan and reset values
        keys = '0;
        do_reset();
        check("reset_num", int'(kif.num), 0);
        check("reset_pressed", int'(kif.key_pressed), 0);
        check("reset_valid", int'(kif.key_valid), 0);
        for (int k = 0; k < 32; k++) begin
            check("idle_col", int'(kif.col), 1 << ((k / 4) % 4));
            @(negedge clk);
        end
        check("idle_strobes", strobes, 0);

        // Steady key col1/row2 -> 8, strobe 12 cycles after col reaches it
        keys[1][2] = 1'b1;
        do_reset();
        exp_q.push_back(4'h8);
        wait_col(4'b0010, n);
        wait_valid(n);
        check("press_latency", n, 12);
        cycles(16);
        check("held_col_frozen", int'(kif.col), 4'b0010);
        check("held_pressed", int'(kif.key_pressed), 1);
        keys = '0;
        cycles(24);
        check("release_pressed", int'(kif.key_pressed), 0);
        check("num_held_after_release", int'(kif.num), 8);
        check("sb_empty_key8", exp_q.size(), 0);

        // Bounce on col0/row3 during debounce: no strobe, then F
        keys = '0;
        do_reset();
        cycles(16);
        check("bounce_col_start", int'(kif.col), 4'b0001);
        s0 = strobes;
        keys[0][3] = 1'b1;
        cycles(4);
        keys = '0;
        cycles(4);
        keys[0][3] = 1'b1;
        cycles(5);
        check("bounce_rescan_col", int'(kif.col), 4'b0100);
        check("bounce_no_press", int'(kif.key_pressed), 0);
        check("bounce_no_strobe", strobes, s0);
        exp_q.push_back(4'hF);
        wait_col(4'b0001, n);
        wait_valid(n);
        check("bounce_then_latency", n, 12);
        keys = '0;
        cycles(30);
        check("sb_empty_keyF", exp_q.size(), 0);

        // Two rows on one column are ignored
        keys = '0;
        keys[2] = 4'b0011;
        do_reset();
        s0 = strobes;
        seen = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            seen |= kif.col;
        end
        check("multi_all_cols", int'(seen), 4'b1111);
        check("multi_no_strobe", strobes, s0);
        check("multi_no_press", int'(kif.key_pressed), 0);
        keys = '0;

        // Asynchronous reset while key D is held, then re-detection
        keys[3][3] = 1'b1;
        do_reset();
        exp_q.push_back(4'hD);
        wait_valid(n);
        cycles(2);
        check("d_pressed", int'(kif.key_pressed), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_col", int'(kif.col), 4'b0001);
        check("async_rst_num", int'(kif.num), 0);
        check("async_rst_pressed", int'(kif.key_pressed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'hD);
        wait_valid(n);
        keys = '0;
        cycles(30);
        check("sb_empty_keyD", exp_q.size(), 0);

`ifdef KEYPAD_REPEAT_EN
        // Held key 5 repeats every 32 cycles, stops on release
        keys[1][1] = 1'b1;
        do_reset();
        exp_q.push_back(4'h5);
        wait_valid(n);
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back(4'h5);
            wait_valid(n);
            check("repeat_period", n, 32);
        end
        keys = '0;
        cycles(60);
        check("repeat_stopped", exp_q.size(), 0);
        check("repeat_released", int'(kif.key_pressed), 0);
`endif

        // Randomized: every key once in shuffled order, free-running scan phase
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            int c, r;
            cycles(int'($urandom_range(0, 15)));
            c = order[i] / 4;
            r = order[i] % 4;
            keys = '0;
            if ($urandom_range(0, 3) == 0) begin
                keys[c] = 4'((1 << r) | (1 << ((r + 1 + int'($urandom_range(0, 2))) % 4)));
                cycles(36);
                keys = '0;
                cycles(30);
            end
            keys = '0;
            keys[c][r] = 1'b1;
            exp_q.push_back(kmap[c][r]);
            cycles(36);
            keys = '0;
            cycles(30);
            check("rand_sb_empty", exp_q.size(), 0);
            check("rand_released", int'(kif.key_pressed), 0);
        end

        check("final_sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
